// File: rtl/bist_ctrl_param.sv
// BIST run controller: sequences seed load, N*M pattern cycles, capture
// strobes, seed-segment and polynomial selection, and end-of-run handshake.
module bist_ctrl_param #(
  parameter int N           = 10,   // clock cycles per pattern block
  parameter int M           = 110,  // pattern blocks per run
  parameter int SEEDS       = 4,    // seed segments per run
  parameter int POLY_SWITCH = 55    // first block using the alternate polynomial
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic                     ABORT,
  output logic                     INIT,
  output logic                     OUT,
  output logic                     CAPTURE,
  output logic [$clog2(SEEDS)-1:0] SEED_SEL,
  output logic                     POLY,
  output logic                     FINISH,
  output logic                     BIST_END,
  output logic                     ABORTED
);

  localparam int NW = $clog2(N);
  localparam int MW = $clog2(M);
  localparam int SW = $clog2(SEEDS);

  // Segment arithmetic is done in 32 bits so every parameter fits unchanged.
  localparam logic [31:0] SEG_LEN  = 32'(M / SEEDS);
  localparam logic [31:0] SEED_MAX = 32'(SEEDS - 1);
  localparam logic [31:0] PSW      = 32'(POLY_SWITCH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_INIT  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [NW-1:0] cnt_n_q, cnt_n_d;
  logic [MW-1:0] cnt_m_q, cnt_m_d;
  logic          aborted_q, aborted_d;

  logic          last_n, last_m;
  logic [31:0]   blk32, seg32;

  assign last_n = (cnt_n_q == NW'(N - 1));
  assign last_m = (cnt_m_q == MW'(M - 1));
  assign blk32  = {{(32-MW){1'b0}}, cnt_m_q};
  assign seg32  = blk32 / SEG_LEN;

  // Next-state and counter logic; ABORT is only honoured in INIT and RUN and
  // takes priority over completion of the final pattern cycle.
  always_comb begin
    state_d   = state_q;
    cnt_n_d   = cnt_n_q;
    cnt_m_d   = cnt_m_q;
    aborted_d = aborted_q;
    case (state_q)
      S_IDLE:  if (!START) state_d = S_ARMED;   // demands a fresh START rise
      S_ARMED: if (START) begin
        state_d   = S_INIT;
        aborted_d = 1'b0;
      end
      S_INIT: begin
        cnt_n_d   = '0;
        cnt_m_d   = '0;
        aborted_d = 1'b0;
        if (ABORT) begin
          state_d   = S_HOLD;
          aborted_d = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (ABORT) begin
          state_d   = S_HOLD;
          aborted_d = 1'b1;
        end else if (last_n) begin
          cnt_n_d = '0;
          if (last_m) state_d = S_FIN;
          else        cnt_m_d = cnt_m_q + MW'(1);
        end else begin
          cnt_n_d = cnt_n_q + NW'(1);
        end
      end
      S_FIN:  state_d = S_HOLD;
      S_HOLD: if (!START) state_d = S_DONE;
      S_DONE: if (START) begin
        state_d   = S_INIT;
        aborted_d = 1'b0;
      end
      default: begin
        state_d   = S_IDLE;
        cnt_n_d   = '0;
        cnt_m_d   = '0;
        aborted_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_n_q   <= '0;
      cnt_m_q   <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_n_q   <= cnt_n_d;
      cnt_m_q   <= cnt_m_d;
      aborted_q <= aborted_d;
    end
  end

  // Moore output decode from state and counters; unknown states drive zeros.
  always_comb begin
    INIT     = 1'b0;
    OUT      = 1'b0;
    CAPTURE  = 1'b0;
    SEED_SEL = '0;
    POLY     = 1'b0;
    FINISH   = 1'b0;
    BIST_END = 1'b0;
    ABORTED  = 1'b0;
    case (state_q)
      S_INIT: INIT = 1'b1;
      S_RUN: begin
        OUT      = 1'b1;
        CAPTURE  = last_n;
        SEED_SEL = (seg32 > SEED_MAX) ? SW'(SEEDS - 1) : seg32[SW-1:0];
        POLY     = (blk32 >= PSW);
      end
      S_FIN: begin
        FINISH   = 1'b1;
        BIST_END = 1'b1;
      end
      S_HOLD, S_DONE: begin
        BIST_END = 1'b1;
        ABORTED  = aborted_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bist_ctrl_param.sv
// Directed-plus-random bench for bist_ctrl_param (N=4, M=8, SEEDS=4, POLY_SWITCH=4).
module tb_bist_ctrl_param;
  localparam int N  = 4;
  localparam int M  = 8;
  localparam int S  = 4;
  localparam int PS = 4;

  logic       CLK = 1'b0;
  logic       RESET, START, ABORT;
  logic       INIT, OUT, CAPTURE, POLY, FINISH, BIST_END, ABORTED;
  logic [1:0] SEED_SEL;

  int checks = 0;
  int errors = 0;

  bist_ctrl_param #(.N(N), .M(M), .SEEDS(S), .POLY_SWITCH(PS)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
    .INIT(INIT), .OUT(OUT), .CAPTURE(CAPTURE), .SEED_SEL(SEED_SEL),
    .POLY(POLY), .FINISH(FINISH), .BIST_END(BIST_END), .ABORTED(ABORTED)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_init"}, 32'(INIT), 0);
    chk({tag, "_out"},  32'(OUT), 0);
    chk({tag, "_cap"},  32'(CAPTURE), 0);
    chk({tag, "_seed"}, 32'(SEED_SEL), 0);
    chk({tag, "_poly"}, 32'(POLY), 0);
    chk({tag, "_fin"},  32'(FINISH), 0);
    chk({tag, "_end"},  32'(BIST_END), 0);
    chk({tag, "_abtd"}, 32'(ABORTED), 0);
  endtask

  // One run starting from ARMED/DONE with START low. abort_at: -2 none,
  // -1 during INIT, k during RUN cycle k. reset_at: RUN cycle for RESET, -1 none.
  task automatic run(input int abort_at, input int reset_at, input bit tog);
    int nout, ncap, blk, seed;
    bit aborted;
    nout = 0; ncap = 0; aborted = 0;
    START = 1'b1;
    tick();
    chk("init_pulse", 32'(INIT), 1);
    chk("init_out",   32'(OUT), 0);
    chk("init_end",   32'(BIST_END), 0);
    chk("init_abtd",  32'(ABORTED), 0);
    if (abort_at == -1) begin
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      aborted = 1;
    end else begin
      for (int k = 0; k < N*M; k++) begin
        tick();
        blk  = k / N;
        seed = blk / (M / S);
        if (seed > S - 1) seed = S - 1;
        chk("run_out",  32'(OUT), 1);
        chk("run_cap",  32'(CAPTURE), 32'((k % N) == N - 1));
        chk("run_seed", 32'(SEED_SEL), 32'(seed));
        chk("run_poly", 32'(POLY), 32'(blk >= PS));
        chk("run_fin",  32'(FINISH), 0);
        chk("run_end",  32'(BIST_END), 0);
        chk("run_init", 32'(INIT), 0);
        nout += int'(OUT);
        ncap += int'(CAPTURE);
        if (tog) START = 1'($urandom_range(0, 1));
        if (k == reset_at) begin
          RESET = 1'b1;
          #1;
          chk_zero("async_rst");
          RESET = 1'b0;
          START = 1'b0;
          tick();
          chk_zero("post_rst");
          return;
        end
        if (k == abort_at) begin
          ABORT = 1'b1;
          tick();
          ABORT = 1'b0;
          aborted = 1;
          break;
        end
      end
    end
    if (aborted) begin
      chk("abort_end",  32'(BIST_END), 1);
      chk("abort_abtd", 32'(ABORTED), 1);
      chk("abort_fin",  32'(FINISH), 0);
      chk("abort_out",  32'(OUT), 0);
    end else begin
      chk("out_count", 32'(nout), 32'(N*M));
      chk("cap_count", 32'(ncap), 32'(M));
      tick();
      chk("fin_pulse", 32'(FINISH), 1);
      chk("fin_end",   32'(BIST_END), 1);
      chk("fin_out",   32'(OUT), 0);
      chk("fin_abtd",  32'(ABORTED), 0);
    end
    // HOLD waits for START low; ABORT here must be ignored.
    START = 1'b1;
    ABORT = 1'b1;
    tick();
    chk("hold_end",  32'(BIST_END), 1);
    chk("hold_fin",  32'(FINISH), 0);
    chk("hold_abtd", 32'(ABORTED), 32'(aborted));
    tick();
    chk("hold_stay", 32'(BIST_END), 1);
    chk("hold_init", 32'(INIT), 0);
    START = 1'b0;
    tick();
    chk("done_end",  32'(BIST_END), 1);
    chk("done_abtd", 32'(ABORTED), 32'(aborted));
    ABORT = 1'b0;
    repeat ($urandom_range(0, 3)) tick();
    chk("done_wait", 32'(BIST_END), 1);
    chk("done_init", 32'(INIT), 0);
  endtask

  initial begin
    RESET = 1'b1; START = 1'b1; ABORT = 1'b0;
    #2;
    chk_zero("reset");
    tick();
    chk_zero("reset_clk");
    // START held high through reset release must not launch a run.
    RESET = 1'b0;
    repeat (3 + $urandom_range(0, 4)) begin
      tick();
      chk("start_held_init", 32'(INIT), 0);
      chk("start_held_out",  32'(OUT), 0);
    end
    START = 1'b0;
    tick();
    chk("armed_init", 32'(INIT), 0);

    run(-2, -1, 1'b0);          // normal run
    run(10, -1, 1'b1);          // abort at RUN cycle 10, START toggling
    run(-2, -1, 1'b1);          // normal run after abort clears ABORTED
    run(N*M-1, -1, 1'b0);       // abort coincident with final cycle
    run(-1, -1, 1'b0);          // abort during INIT
    run(-2, 17, 1'b1);          // reset mid-run
    run(-2, -1, 1'b1);          // full run after reset
    run($urandom_range(0, N*M-1), -1, 1'b1);
    run(-2, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
